xb_read_stream_source: RTL and testbench

- FPGA-side producer for a Xillybus FPGA-to-CPU read stream (user_r_* signal set), clocked on bus_clk.
- Accepts samples from user logic over a valid/ready port and buffers them in an internal FIFO.
- Presents the buffered samples to the core with rden/empty semantics, and signals end-of-file after a fixed-length frame.
- Sits between an acquisition block and a xillybus read-stream port, in the same place a loopback FIFO would otherwise sit.

---
 rtl/xb_stream_pkg.sv | 27 ++
 rtl/xb_sync_fifo.sv | 59 +++++
 rtl/xb_read_stream_source.sv | 135 +++++++++++++
 tb/tb_xb_read_stream_source.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/xb_stream_pkg.sv
// xb_stream_pkg
//   Shared definitions for the xillybus read-stream source:
//   - xb_state_e : frame state machine encoding
//   - xb_cnt_w() : width of the push/pop session counters
//   - default frame length and FIFO depth exponent
package xb_stream_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      EOF   = 3'd3,
      DONE  = 3'd4
   } xb_state_e;

   localparam int unsigned XB_FRAME_LEN_DEF  = 1024;
   localparam int          XB_DEPTH_LOG2_DEF = 4;

   // Counters are at least 32 bits wide.  They only grow past that if the
   // frame length needs more, which a 32-bit parameter never does.
   function automatic int xb_cnt_w(input int unsigned frame_len);
      int w;
      w = $clog2({1'b0, frame_len} + 33'd1);
      return (w > 32) ? w : 32;
   endfunction

endpackage

// File: rtl/xb_sync_fifo.sv
// xb_sync_fifo
//   Single-clock FIFO, 2**AW words, registered read data.
//   Pointers carry an extra MSB so full and empty can be told apart.
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   flush            drop all contents (pointers to 0), read data kept
//   push, push_data  write one word (ignored when full)
//   pop              read one word (ignored when empty)
//   pop_data         word read by the last pop, valid the cycle after pop
//   full, empty      occupancy flags
//   count            current occupancy, 0..2**AW
module xb_sync_fifo #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          do_push;
   logic          do_pop;

   assign count   = wptr - rptr;
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (srst)        pop_data <= '0;
      else if (do_pop) pop_data <= mem[rptr[AW-1:0]];
   end

endmodule

// File: rtl/xb_read_stream_source.sv
// xb_read_stream_source
//   FPGA-to-CPU xillybus read-stream producer.  Samples arrive on a
//   valid/ready port, are buffered in a FIFO and handed to the core with
//   rden/empty semantics.  After FRAME_LEN words an EOF pulse closes the
//   session (FRAME_LEN=0: endless stream, no EOF).
// Ports:
//   bus_clk, srst              clock, synchronous active-high reset
//   quiesce, user_r_open       session control (quiesce acts as close)
//   user_r_rden/empty/data/eof xillybus read-stream interface
//   src_valid/ready/data       sample input
//   frame_busy                 session in RUN or DRAIN
// Build option:
//   XB_SRC_TESTPATTERN_EN      replace the sample input by an internal
//                              counter pattern (0,1,2,... per session)
module xb_read_stream_source
   import xb_stream_pkg::*;
#(
   parameter int          DW         = 32,
   parameter int          DEPTH_LOG2 = XB_DEPTH_LOG2_DEF,
   parameter int unsigned FRAME_LEN  = XB_FRAME_LEN_DEF
) (
   input  logic          bus_clk,
   input  logic          srst,
   input  logic          quiesce,
   input  logic          user_r_open,
   input  logic          user_r_rden,
   output logic          user_r_empty,
   output logic [DW-1:0] user_r_data,
   output logic          user_r_eof,
   input  logic          src_valid,
   output logic          src_ready,
   input  logic [DW-1:0] src_data,
   output logic          frame_busy
);

   localparam int            CW      = xb_cnt_w(FRAME_LEN);
   localparam logic [CW-1:0] FL      = CW'(FRAME_LEN);
   localparam bit            ENDLESS = (FRAME_LEN == 0);

   xb_state_e         state, state_nxt;
   logic [CW-1:0]     push_cnt, pop_cnt;
   logic              open_ok;
   logic              room;
   logic              push, pop;
   logic [DW-1:0]     push_data;
   logic              fifo_full, fifo_empty, fifo_flush;
   logic [DEPTH_LOG2:0] fifo_cnt;
   logic              empty_q;
   logic              run_nxt;

   assign open_ok    = user_r_open && !quiesce;
   assign room       = !fifo_full && (ENDLESS || (push_cnt < FL));
   assign pop        = user_r_rden && !empty_q;
   assign fifo_flush = !open_ok || (state == IDLE);

`ifdef XB_SRC_TESTPATTERN_EN
   logic [DW-1:0] tp_cnt;
   logic          unused_src;

   assign unused_src = ^{src_valid, src_data};
   assign src_ready  = 1'b0;
   assign push       = (state == RUN) && room;
   assign push_data  = tp_cnt;

   // Pattern restarts at 0 every session: it is held at 0 outside RUN.
   always_ff @(posedge bus_clk) begin
      if (srst || state != RUN) tp_cnt <= '0;
      else if (push)            tp_cnt <= tp_cnt + 1'b1;
   end
`else
   assign src_ready = (state == RUN) && room;
   assign push      = src_valid && src_ready;
   assign push_data = src_data;
`endif

   xb_sync_fifo #(.DW(DW), .AW(DEPTH_LOG2)) u_fifo (
      .clk       (bus_clk),
      .srst      (srst),
      .flush     (fifo_flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (user_r_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_cnt)
   );

   always_ff @(posedge bus_clk) begin
      if (srst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!open_ok) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (!ENDLESS && push_cnt == FL) state_nxt = DRAIN;
            DRAIN:   if (pop_cnt == FL && fifo_empty) state_nxt = EOF;
            EOF:     state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Session counters saturate instead of wrapping.
   always_ff @(posedge bus_clk) begin
      if (srst || fifo_flush) begin
         push_cnt <= '0;
         pop_cnt  <= '0;
      end else begin
         if (push && push_cnt != '1) push_cnt <= push_cnt + CW'(1);
         if (pop  && pop_cnt  != '1) pop_cnt  <= pop_cnt  + CW'(1);
      end
   end

   // Registered empty.  A pop this cycle is subtracted right away so the
   // core can never pop the last word twice; a push this cycle is not
   // counted, so new data shows up one cycle after it lands.
   assign run_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);

   always_ff @(posedge bus_clk) begin
      if (srst) empty_q <= 1'b1;
      else      empty_q <= ((fifo_cnt - (DEPTH_LOG2+1)'(pop)) == '0) || !run_nxt;
   end

   assign user_r_empty = empty_q;
   assign user_r_eof   = (state == EOF);
   assign frame_busy   = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_xb_read_stream_source.sv
// Bench for xb_read_stream_source (default build, test pattern off).
// DUT A: 4-deep FIFO, 6-word frames.  DUT B: endless stream.
module tb_xb_read_stream_source;

   logic        bus_clk = 1'b0;
   logic        srst;
   logic        a_q, a_open, a_rden, a_empty, a_eof, a_valid, a_ready, a_busy;
   logic [31:0] a_data, a_rdata;
   logic        b_q, b_open, b_rden, b_empty, b_eof, b_valid, b_ready, b_busy;
   logic [31:0] b_data, b_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 bus_clk = ~bus_clk;

   xb_read_stream_source #(.DW(32), .DEPTH_LOG2(2), .FRAME_LEN(6)) u_a (
      .bus_clk(bus_clk), .srst(srst), .quiesce(a_q), .user_r_open(a_open),
      .user_r_rden(a_rden), .user_r_empty(a_empty), .user_r_data(a_rdata),
      .user_r_eof(a_eof), .src_valid(a_valid), .src_ready(a_ready),
      .src_data(a_data), .frame_busy(a_busy));

   xb_read_stream_source #(.DW(32), .DEPTH_LOG2(4), .FRAME_LEN(0)) u_b (
      .bus_clk(bus_clk), .srst(srst), .quiesce(b_q), .user_r_open(b_open),
      .user_r_rden(b_rden), .user_r_empty(b_empty), .user_r_data(b_rdata),
      .user_r_eof(b_eof), .src_valid(b_valid), .src_ready(b_ready),
      .src_data(b_data), .frame_busy(b_busy));

   typedef struct {
      logic        o, q, r, v;
      logic [31:0] d;
      logic        e, rdy, eof, busy;
      logic [31:0] data;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(input logic o, q, r, v, input logic [31:0] d,
                               input logic e, rdy, eof, busy, input logic [31:0] data);
      vec_t t;
      t.o = o; t.q = q; t.r = r; t.v = v; t.d = d;
      t.e = e; t.rdy = rdy; t.eof = eof; t.busy = busy; t.data = data;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge bus_clk);
      #1;
   endtask

   task automatic a_set(input logic o, q, r, v, input logic [31:0] d);
      a_open = o; a_q = q; a_rden = r; a_valid = v; a_data = d;
   endtask

   // Push n words base.. while popping whenever data is offered; checks order,
   // a single one-cycle eof, and that eof comes only after the last pop.
   task automatic a_frame(input logic [31:0] base, input int n, input string tag);
      int  pushed = 0, popped = 0, eofs = 0, early = 0;
      bit  pre_rdy, pre_pop;
      for (int c = 0; c < 40; c++) begin
         a_valid = (pushed < n);
         a_data  = base + pushed;
         a_rden  = !a_empty;
         pre_rdy = a_ready;
         pre_pop = a_rden && !a_empty;
         step();
         if (a_valid && pre_rdy) pushed++;
         if (pre_pop) begin
            chk({tag, "_data"}, a_rdata, base + popped);
            popped++;
         end
         if (a_eof) begin
            eofs++;
            if (popped != n) early++;
         end
      end
      a_valid = 1'b0; a_rden = 1'b0;
      chk({tag, "_pushed"}, pushed, n);
      chk({tag, "_popped"}, popped, n);
      chk({tag, "_eof_cycles"}, eofs, 1);
      chk({tag, "_eof_early"}, early, 0);
   endtask

   initial begin
      int  acc, eofs, pushed, popped, cyc;
      bit  pre_rdy, pre_pop;

      srst = 1'b1;
      a_set(0, 0, 0, 0, 0);
      b_open = 0; b_q = 0; b_rden = 0; b_valid = 0; b_data = 0;
      step(); step();
      chk("rst_a_empty", a_empty, 1);
      chk("rst_a_eof",   a_eof,   0);
      chk("rst_a_data",  a_rdata, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_a_busy",  a_busy,  0);
      chk("rst_b_empty", b_empty, 1);
      chk("rst_b_ready", b_ready, 0);
      srst = 1'b0;
      step();

      // Frame with no backpressure; rows hold outputs after the edge.
      tbl[0]  = mk(1,0,0,0,32'h00,   1,1,0,1,32'h00);
      tbl[1]  = mk(1,0,0,1,32'hA0,   1,1,0,1,32'h00);
      tbl[2]  = mk(1,0,0,1,32'hA1,   0,1,0,1,32'h00);
      tbl[3]  = mk(1,0,1,1,32'hA2,   0,1,0,1,32'hA0);
      tbl[4]  = mk(1,0,1,1,32'hA3,   0,1,0,1,32'hA1);
      tbl[5]  = mk(1,0,1,1,32'hA4,   0,1,0,1,32'hA2);
      tbl[6]  = mk(1,0,1,1,32'hA5,   0,0,0,1,32'hA3);
      tbl[7]  = mk(1,0,1,0,32'h00,   0,0,0,1,32'hA4);
      tbl[8]  = mk(1,0,1,0,32'h00,   1,0,0,1,32'hA5);
      tbl[9]  = mk(1,0,1,0,32'h00,   1,0,1,0,32'hA5);
      tbl[10] = mk(1,0,0,0,32'h00,   1,0,0,0,32'hA5);
      tbl[11] = mk(1,0,0,0,32'h00,   1,0,0,0,32'hA5);
      tbl[12] = mk(0,0,0,0,32'h00,   1,0,0,0,32'hA5);
      for (int i = 0; i < 13; i++) begin
         a_set(tbl[i].o, tbl[i].q, tbl[i].r, tbl[i].v, tbl[i].d);
         step();
         chk($sformatf("vec%0d_empty", i), a_empty, tbl[i].e);
         chk($sformatf("vec%0d_ready", i), a_ready, tbl[i].rdy);
         chk($sformatf("vec%0d_eof",   i), a_eof,   tbl[i].eof);
         chk($sformatf("vec%0d_busy",  i), a_busy,  tbl[i].busy);
         chk($sformatf("vec%0d_data",  i), a_rdata, tbl[i].data);
      end

      // Full FIFO: 4 of 6 offered accepted; a pop frees space one cycle later.
      a_set(1, 0, 0, 0, 0);
      step();
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         a_set(1, 0, 0, 1, 32'hB0 + acc);
         pre_rdy = a_ready;
         step();
         if (pre_rdy) acc++;
      end
      chk("full_accepted", acc, 4);
      chk("full_ready_low", a_ready, 0);
      a_set(1, 0, 1, 1, 32'hB4);
      chk("full_no_push_with_pop", a_ready, 0);
      step();
      chk("full_pop_data", a_rdata, 32'hB0);
      chk("full_ready_after_pop", a_ready, 1);
      a_set(1, 0, 0, 1, 32'hB4);
      step();
      chk("full_fifth_taken", a_ready, 0);

      // Close mid-frame, then a fresh session must start clean.
      a_set(0, 0, 0, 0, 0);
      step();
      chk("close_empty", a_empty, 1);
      chk("close_busy",  a_busy,  0);
      chk("close_ready", a_ready, 0);
      a_set(1, 0, 0, 0, 0);
      step();
      a_frame(32'h11, 6, "reopen");

      // Quiesce during RUN flushes like a close and never yields eof.
      a_set(0, 0, 0, 0, 0); step();
      a_set(1, 0, 0, 0, 0); step();
      for (int i = 0; i < 3; i++) begin
         a_set(1, 0, 0, 1, 32'hC0 + i);
         step();
      end
      eofs = 0;
      a_set(1, 1, 0, 0, 0);
      step();
      chk("quiesce_empty", a_empty, 1);
      chk("quiesce_busy",  a_busy,  0);
      for (int i = 0; i < 5; i++) begin
         a_set(1, 1, 1, 0, 0);
         step();
         if (a_eof || !a_empty) eofs++;
      end
      chk("quiesce_quiet", eofs, 0);
      a_set(1, 0, 0, 0, 0);
      step();
      // rden while empty: data must hold and no pointer may move.
      a_set(1, 0, 1, 0, 0);
      step();
      chk("viol_data_hold", a_rdata, 32'h16);
      chk("viol_empty", a_empty, 1);
      a_rden = 1'b0;
      a_frame(32'h40, 6, "after_quiesce");

      // Endless stream on DUT B.
      b_open = 1'b1;
      step();
      pushed = 0; popped = 0; eofs = 0; cyc = 0;
      while (popped < 5000 && cyc < 12000) begin
         b_valid = (pushed < 5000);
         b_data  = pushed;
         b_rden  = !b_empty;
         pre_rdy = b_ready;
         pre_pop = b_rden && !b_empty;
         step();
         cyc++;
         if (b_valid && pre_rdy) pushed++;
         if (pre_pop) begin
            if (b_rdata !== popped) chk("stream_data", b_rdata, popped);
            popped++;
         end
         if (b_eof) eofs++;
      end
      b_valid = 1'b0; b_rden = 1'b0;
      chk("stream_popped", popped, 5000);
      chk("stream_no_eof", eofs, 0);
      chk("stream_busy", b_busy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
